// File: rtl/seq_adder_mult_ctrl_if.sv
// rtl/seq_adder_mult_ctrl_if.sv - request/result bundle for the repeated-addition multiplier
interface seq_adder_mult_ctrl_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         ovf;

  modport master (
    output start, a, b,
    input  busy, done, result, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, result, ovf
  );
endinterface

// File: rtl/seq_adder_mult_ctrl.sv
// rtl/seq_adder_mult_ctrl.sv - sequences clear/enable of an accumulating adder to form a*b
module seq_adder_mult_ctrl #(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  seq_adder_mult_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_ADD   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [W-1:0] r_a;
  logic [W-1:0] r_cnt;
  logic [W-1:0] r_acc;
  logic         r_ovf;
  logic [W:0]   w_sum;
  logic         w_cnt_zero;

  assign w_sum      = {1'b0, r_acc} + {1'b0, r_a};
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_CLEAR;
      S_CLEAR: w_next = S_ADD;
      S_ADD:   if (w_cnt_zero) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operands are only sampled in IDLE, so the inputs may change freely once accepted
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_a   <= '0;
      r_cnt <= '0;
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a   <= bus.a;
            r_cnt <= bus.b;
          end
        end
        S_CLEAR: begin
          r_acc <= '0;
          r_ovf <= 1'b0;
        end
        S_ADD: begin
          if (!w_cnt_zero) begin
            r_acc <= w_sum[W-1:0];
            r_ovf <= r_ovf | w_sum[W];
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy   = (r_state != S_IDLE);
    bus.done   = (r_state == S_DONE);
    bus.result = r_acc;
    bus.ovf    = r_ovf;
  end

endmodule
